game_rom_arbiter: RTL and testbench
===================================

# game_rom_arbiter

Sequences game loading and shares the PRG and CHR ROM memory ports between the SoC game-ROM programmer and the running NES. Programmer writes go through a 4-entry write FIFO that drains into the single-port PRG/CHR memories. The block holds the NES in reset while a game loads, then releases it after a fixed hold interval. After release, programmer writes (hot patches) only use memory cycles that CPU/PPU reads leave idle.

## Interface
- HOLD_CYCLES, 16, cycles the NES reset is held after the FIFO drains (≥1)
- FIFO_DEPTH, 4, write FIFO entries (power of two)
- Clk  in  1  single clock, all logic on posedge
- Reset_n  in  1  asynchronous, active-low reset
- load_start  in  1  pulse: begin a game load
- load_done  in  1  pulse: programmer finished issuing writes
- prg_wren / chr_wren  in  1 each  one write per high cycle; both high = CHR ignored, PRG taken
- wr_addr  in  16  write address (PRG uses [14:0], CHR uses [12:0])
- wr_data  in  8  write byte
- wr_ready  out  1  FIFO not full
- cpu_rd / cpu_addr  in  1 / 15  CPU PRG read request
- ppu_rd / ppu_addr  in  1 / 13  PPU CHR read request
- cpu_rd_valid / ppu_rd_valid  out  1 each  memory data valid this cycle
- prg_mem_addr / prg_mem_wdata / prg_mem_we  out  15 / 8 / 1  PRG port
- chr_mem_addr / chr_mem_wdata / chr_mem_we  out  13 / 8 / 1  CHR port
- nes_reset_hold  out  1  active-high reset to the NES
- state  out  2  LOAD=0, DRAIN=1, HOLD=2, RUN=3
- wr_dropped  out  1  sticky: a write arrived while the FIFO was full
- write_count  out  16  committed writes since the last LOAD entry (wraps)
- checksum  out  8  see Configuration

## Operation
- FIFO entry = {target bit (PRG/CHR), addr[15:0], data[7:0]}. Push when a wren is high and wr_ready=1.
- A wren while the FIFO is full is dropped and sets wr_dropped. Only reset or LOAD entry clears wr_dropped.
- FSM:
  - LOAD: nes_reset_hold=1. The FIFO head drains every cycle. Reads are ignored.
  - LOAD → DRAIN on load_done.
  - DRAIN: same as LOAD. Moves to HOLD when the FIFO is empty and no push happens that cycle. The hold counter loads with HOLD_CYCLES-1.
  - HOLD: nes_reset_hold=1. Reads and writes are arbitrated as in RUN. Moves to RUN when the counter reaches 0.
  - RUN: nes_reset_hold=0.
  - load_start in any state → LOAD. load_start beats load_done when both arrive in the same cycle. Entering LOAD clears write_count, checksum and wr_dropped. The FIFO contents are kept.
- Arbitration in HOLD/RUN, per port:
  - A read request owns the port and is never stalled.
  - The FIFO head drains only when its target port has no read that cycle.
  - A blocked head stalls the whole FIFO (in-order commit).
  - A PRG read does not block a CHR head, and vice versa.
- Memory outputs are combinational from the read inputs and FIFO head. mem_we=0 and addr=0 when the port is idle.
- write_count and checksum update on every mem_we.

## Timing
- Reset values: state=LOAD, nes_reset_hold=1, wr_ready=1, all mem_we=0, rd_valid=0, wr_dropped=0, write_count=0, checksum=0, FIFO empty.
- Write accepted at cycle t → earliest mem_we at t+1. Peak throughput is 1 write/cycle in LOAD.
- Read at t (HOLD/RUN) → rd_valid=1 at t+1, matching a 1-cycle synchronous memory.
- wr_ready is registered and deasserts in the cycle after the push that fills the FIFO. Simultaneous push and pop at full is allowed.
- RUN is reached exactly HOLD_CYCLES cycles after DRAIN exits.
- Reset_n low mid-operation: all state cleared immediately. A partial load is not resumed.

## Configuration
- GAME_ROM_ARBITER_CHECKSUM_EN:
  - Defined: checksum = 8-bit modular sum of all committed bytes since LOAD entry.
  - Undefined: no checksum logic; checksum is tied to 8'h00.

## Structure
- Shared package `nes_pkg` holds:
  - the state enum (LOAD, DRAIN, HOLD, RUN);
  - the FIFO entry struct;
  - the constants PRG_AW=15 and CHR_AW=13.
- One sub-module, `rom_wr_fifo`: synchronous FIFO with push/pop/full/empty/head, parameterised by depth and entry type.

## Test plan
- Reset release, load_start, then 8 PRG writes 0x8000–0x8007 with data 0x01–0x08, then load_done → prg_mem_we one cycle after each write; DRAIN→HOLD; RUN exactly 16 cycles later; write_count=8; checksum=0x24 with the macro defined.
- In RUN, cpu_rd held high continuously while 5 PRG writes arrive back-to-back → wr_ready falls after the 4th push, the 5th write is dropped, wr_dropped=1, prg_mem_we stays 0. Releasing cpu_rd commits the 4 writes on 4 consecutive cycles.
- In RUN, ppu_rd high continuously while 2 PRG writes arrive → PRG writes commit at t+1 and t+2, unaffected by CHR traffic.
- prg_wren and chr_wren high together with addr 0x0010 → exactly one PRG write to address 0x0010.
- load_start and load_done in the same cycle during DRAIN → state=LOAD, write_count=0, nes_reset_hold stays 1.
- Reset_n pulsed low during HOLD → all outputs return to reset values asynchronously; state=LOAD on release.

Source files
------------

// File: rtl/nes_pkg.sv
// Shared definitions for the game-ROM loading path.
//   state_t    : loader/arbiter FSM states (LOAD, DRAIN, HOLD, RUN)
//   wr_entry_t : one queued programmer write {target, addr, data}
//   PRG_AW / CHR_AW : PRG and CHR memory address widths
package nes_pkg;

    localparam int PRG_AW = 15;
    localparam int CHR_AW = 13;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2,
        RUN   = 2'd3
    } state_t;

    // is_chr = 0 targets PRG, 1 targets CHR.
    typedef struct packed {
        logic        is_chr;
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_entry_t;

endpackage

// File: rtl/rom_wr_fifo.sv
// Synchronous FIFO for queued ROM writes.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset (control only)
//   push, push_data     : enqueue (ignored while full)
//   pop                 : dequeue the head (ignored while empty)
//   head                : current head entry (valid when !empty)
//   full                : registered full flag, updates the cycle after the filling push
//   empty               : no entries stored
// Parameters: DEPTH (power of two, >= 2), entry_t (stored type).
module rom_wr_fifo #(
    parameter int  DEPTH   = 4,
    parameter type entry_t = logic [7:0]
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output entry_t head,
    output logic   full,
    output logic   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    entry_t        mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          full_q, full_d;
    logic          do_push, do_pop;

    assign do_push = push && !full_q;
    assign do_pop  = pop && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
        full_d = (count_d == FULL_CNT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
        end
    end

    // Storage holds data only; validity is tracked by the pointers above.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = (count_q == '0);

endmodule

// File: rtl/game_rom_arbiter.sv
// Game load sequencer and PRG/CHR ROM port arbiter.
// Programmer writes queue in a small FIFO and drain into single-port PRG/CHR
// memories. The NES is held in reset during load, then for HOLD_CYCLES after
// the FIFO drains. Afterwards CPU/PPU reads own their port; queued writes use
// only idle cycles and commit strictly in order.
// Ports:
//   Clk, Reset_n                 : clock, asynchronous active-low reset
//   load_start, load_done        : load sequencing pulses
//   prg_wren, chr_wren, wr_addr, wr_data, wr_ready, wr_dropped : write side
//   cpu_rd/cpu_addr/cpu_rd_valid : CPU PRG reads
//   ppu_rd/ppu_addr/ppu_rd_valid : PPU CHR reads
//   prg_mem_*, chr_mem_*         : memory ports (combinational)
//   nes_reset_hold, state        : NES reset and FSM state
//   write_count, checksum        : committed-write statistics since LOAD entry
// Optional: GAME_ROM_ARBITER_CHECKSUM_EN enables the running byte checksum;
// without it checksum is tied to zero.
module game_rom_arbiter
    import nes_pkg::*;
#(
    parameter int HOLD_CYCLES = 16,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        load_start,
    input  logic        load_done,
    input  logic        prg_wren,
    input  logic        chr_wren,
    input  logic [15:0] wr_addr,
    input  logic [7:0]  wr_data,
    output logic        wr_ready,
    input  logic        cpu_rd,
    input  logic [14:0] cpu_addr,
    input  logic        ppu_rd,
    input  logic [12:0] ppu_addr,
    output logic        cpu_rd_valid,
    output logic        ppu_rd_valid,
    output logic [14:0] prg_mem_addr,
    output logic [7:0]  prg_mem_wdata,
    output logic        prg_mem_we,
    output logic [12:0] chr_mem_addr,
    output logic [7:0]  chr_mem_wdata,
    output logic        chr_mem_we,
    output logic        nes_reset_hold,
    output logic [1:0]  state,
    output logic        wr_dropped,
    output logic [15:0] write_count,
    output logic [7:0]  checksum
);

    localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    state_t         state_q, state_d;
    logic [HCW-1:0] hold_cnt_q, hold_cnt_d;
    logic           wr_dropped_q, wr_dropped_d;
    logic [15:0]    write_count_q, write_count_d;
    logic           cpu_rd_valid_q, ppu_rd_valid_q;

    wr_entry_t push_entry, head;
    logic      wr_req, push, pop, fifo_full, fifo_empty;
    logic      arb_mode, cpu_rd_eff, ppu_rd_eff, head_blocked;
    logic      unused_head_bits;

    // PRG wins when both enables are high.
    assign wr_req            = prg_wren || chr_wren;
    assign push              = wr_req && !fifo_full;
    assign push_entry.is_chr = !prg_wren;
    assign push_entry.addr   = wr_addr;
    assign push_entry.data   = wr_data;

    // Reads only exist once the loader has released the bus to arbitration.
    assign arb_mode     = (state_q == HOLD) || (state_q == RUN);
    assign cpu_rd_eff   = arb_mode && cpu_rd;
    assign ppu_rd_eff   = arb_mode && ppu_rd;
    assign head_blocked = head.is_chr ? ppu_rd_eff : cpu_rd_eff;
    assign pop          = !fifo_empty && !head_blocked;

    rom_wr_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (wr_entry_t)
    ) u_fifo (
        .clk       (Clk),
        .rst_n     (Reset_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign unused_head_bits = head.addr[15];

    // Memory ports: a read owns its port; otherwise the head may write it.
    always_comb begin
        prg_mem_addr  = '0;
        prg_mem_wdata = '0;
        prg_mem_we    = 1'b0;
        chr_mem_addr  = '0;
        chr_mem_wdata = '0;
        chr_mem_we    = 1'b0;
        if (cpu_rd_eff) begin
            prg_mem_addr = cpu_addr;
        end else if (pop && !head.is_chr) begin
            prg_mem_addr  = head.addr[PRG_AW-1:0];
            prg_mem_wdata = head.data;
            prg_mem_we    = 1'b1;
        end
        if (ppu_rd_eff) begin
            chr_mem_addr = ppu_addr;
        end else if (pop && head.is_chr) begin
            chr_mem_addr  = head.addr[CHR_AW-1:0];
            chr_mem_wdata = head.data;
            chr_mem_we    = 1'b1;
        end
    end

    // FSM next state; load_start overrides everything including load_done.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            LOAD: begin
                if (load_done) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (fifo_empty && !push) begin
                    state_d    = HOLD;
                    hold_cnt_d = HCW'(HOLD_CYCLES - 1);
                end
            end
            HOLD: begin
                if (hold_cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q - 1'b1;
                end
            end
            default: ;
        endcase
        if (load_start) begin
            state_d = LOAD;
        end
    end

    always_comb begin
        wr_dropped_d  = wr_dropped_q;
        write_count_d = write_count_q;
        if (load_start) begin
            wr_dropped_d  = 1'b0;
            write_count_d = '0;
        end else begin
            if (wr_req && fifo_full) begin
                wr_dropped_d = 1'b1;
            end
            if (pop) begin
                write_count_d = write_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q        <= LOAD;
            hold_cnt_q     <= '0;
            wr_dropped_q   <= 1'b0;
            write_count_q  <= '0;
            cpu_rd_valid_q <= 1'b0;
            ppu_rd_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            hold_cnt_q     <= hold_cnt_d;
            wr_dropped_q   <= wr_dropped_d;
            write_count_q  <= write_count_d;
            cpu_rd_valid_q <= cpu_rd_eff;
            ppu_rd_valid_q <= ppu_rd_eff;
        end
    end

`ifdef GAME_ROM_ARBITER_CHECKSUM_EN
    logic [7:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (load_start) begin
            checksum_d = '0;
        end else if (pop) begin
            checksum_d = checksum_q + head.data;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = 8'h00;
`endif

    assign wr_ready       = !fifo_full;
    assign cpu_rd_valid   = cpu_rd_valid_q;
    assign ppu_rd_valid   = ppu_rd_valid_q;
    assign nes_reset_hold = (state_q != RUN);
    assign state          = state_q;
    assign wr_dropped     = wr_dropped_q;
    assign write_count    = write_count_q;

endmodule

// File: tb/tb_game_rom_arbiter.sv
// Directed bench for game_rom_arbiter (HOLD_CYCLES=16, FIFO_DEPTH=4).
// Inputs change 1 time unit after a rising edge; combinational outputs are
// sampled 1 unit later, registered outputs 1 unit after the next rising edge.
module tb_game_rom_arbiter;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        load_start, load_done, prg_wren, chr_wren;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ready;
    logic        cpu_rd, ppu_rd;
    logic [14:0] cpu_addr;
    logic [12:0] ppu_addr;
    logic        cpu_rd_valid, ppu_rd_valid;
    logic [14:0] prg_mem_addr;
    logic [7:0]  prg_mem_wdata, chr_mem_wdata;
    logic        prg_mem_we, chr_mem_we;
    logic [12:0] chr_mem_addr;
    logic        nes_reset_hold;
    logic [1:0]  state;
    logic        wr_dropped;
    logic [15:0] write_count;
    logic [7:0]  checksum;

    int checks = 0;
    int errors = 0;

`ifdef GAME_ROM_ARBITER_CHECKSUM_EN
    localparam logic [7:0] CS_LOAD8 = 8'h24;
`else
    localparam logic [7:0] CS_LOAD8 = 8'h00;
`endif

    game_rom_arbiter #(.HOLD_CYCLES(16), .FIFO_DEPTH(4)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .load_start(load_start), .load_done(load_done),
        .prg_wren(prg_wren), .chr_wren(chr_wren),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .cpu_rd(cpu_rd), .cpu_addr(cpu_addr), .ppu_rd(ppu_rd), .ppu_addr(ppu_addr),
        .cpu_rd_valid(cpu_rd_valid), .ppu_rd_valid(ppu_rd_valid),
        .prg_mem_addr(prg_mem_addr), .prg_mem_wdata(prg_mem_wdata), .prg_mem_we(prg_mem_we),
        .chr_mem_addr(chr_mem_addr), .chr_mem_wdata(chr_mem_wdata), .chr_mem_we(chr_mem_we),
        .nes_reset_hold(nes_reset_hold), .state(state), .wr_dropped(wr_dropped),
        .write_count(write_count), .checksum(checksum)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " state"}, 32'(state), 32'd0);
        chk({tag, " hold"}, 32'(nes_reset_hold), 32'd1);
        chk({tag, " wr_ready"}, 32'(wr_ready), 32'd1);
        chk({tag, " prg_we"}, 32'(prg_mem_we), 32'd0);
        chk({tag, " chr_we"}, 32'(chr_mem_we), 32'd0);
        chk({tag, " prg_addr"}, 32'(prg_mem_addr), 32'd0);
        chk({tag, " cpu_vld"}, 32'(cpu_rd_valid), 32'd0);
        chk({tag, " ppu_vld"}, 32'(ppu_rd_valid), 32'd0);
        chk({tag, " dropped"}, 32'(wr_dropped), 32'd0);
        chk({tag, " wcount"}, 32'(write_count), 32'd0);
        chk({tag, " checksum"}, 32'(checksum), 32'd0);
    endtask

    initial begin
        Reset_n = 1'b0;
        load_start = 0; load_done = 0; prg_wren = 0; chr_wren = 0;
        wr_addr = '0; wr_data = '0; cpu_rd = 0; ppu_rd = 0; cpu_addr = '0; ppu_addr = '0;
        #1;
        chk_reset_vals("rst");
        step();
        Reset_n = 1'b1;

        // Test 1: load 8 PRG bytes, drain, hold, run
        load_start = 1;
        step();
        load_start = 0;
        for (int i = 0; i < 8; i++) begin
            prg_wren = 1;
            wr_addr  = 16'h8000 + 16'(i);
            wr_data  = 8'(i + 1);
            #1;
            chk("load wr_ready", 32'(wr_ready), 32'd1);
            if (i == 0) begin
                chk("load first we", 32'(prg_mem_we), 32'd0);
            end else begin
                chk("load we", 32'(prg_mem_we), 32'd1);
                chk("load addr", 32'(prg_mem_addr), 32'(i - 1));
                chk("load data", 32'(prg_mem_wdata), 32'(i));
            end
            step();
        end
        prg_wren  = 0;
        load_done = 1;
        #1;
        chk("load last we", 32'(prg_mem_we), 32'd1);
        chk("load last addr", 32'(prg_mem_addr), 32'd7);
        chk("load last data", 32'(prg_mem_wdata), 32'd8);
        step();
        load_done = 0;
        chk("drain state", 32'(state), 32'd1);
        chk("drain wcount", 32'(write_count), 32'd8);
        chk("drain checksum", 32'(checksum), 32'(CS_LOAD8));
        step();
        chk("hold state", 32'(state), 32'd2);
        chk("hold nes_reset", 32'(nes_reset_hold), 32'd1);
        repeat (15) step();
        chk("hold last state", 32'(state), 32'd2);
        step();
        chk("run state", 32'(state), 32'd3);
        chk("run nes_reset", 32'(nes_reset_hold), 32'd0);

        // Test 2: CPU read blocks PRG drain, FIFO fills, 5th write dropped
        cpu_rd   = 1;
        cpu_addr = 15'h0123;
        for (int k = 0; k < 5; k++) begin
            prg_wren = 1;
            wr_addr  = 16'h9000 + 16'(k);
            wr_data  = 8'h10 + 8'(k);
            #1;
            chk("blk wr_ready", 32'(wr_ready), (k < 4) ? 32'd1 : 32'd0);
            chk("blk prg_we", 32'(prg_mem_we), 32'd0);
            chk("blk prg_addr", 32'(prg_mem_addr), 32'h0123);
            step();
            if (k == 0) chk("blk cpu_vld", 32'(cpu_rd_valid), 32'd1);
        end
        chk("blk dropped", 32'(wr_dropped), 32'd1);
        prg_wren = 0;
        #1;
        chk("blk idle we", 32'(prg_mem_we), 32'd0);
        step();
        cpu_rd = 0;
        for (int j = 0; j < 4; j++) begin
            #1;
            chk("rel we", 32'(prg_mem_we), 32'd1);
            chk("rel addr", 32'(prg_mem_addr), 32'h1000 + 32'(j));
            chk("rel data", 32'(prg_mem_wdata), 32'h10 + 32'(j));
            step();
            if (j == 0) chk("rel wr_ready", 32'(wr_ready), 32'd1);
        end
        chk("rel empty", 32'(prg_mem_we), 32'd0);
        chk("rel wcount", 32'(write_count), 32'd12);
        chk("rel cpu_vld", 32'(cpu_rd_valid), 32'd0);

        // Test 3: PPU reads do not block PRG writes
        ppu_rd   = 1;
        ppu_addr = 13'h0055;
        prg_wren = 1; wr_addr = 16'hA000; wr_data = 8'h31;
        #1;
        chk("ppu chr_addr", 32'(chr_mem_addr), 32'h55);
        chk("ppu chr_we", 32'(chr_mem_we), 32'd0);
        chk("ppu prg_we0", 32'(prg_mem_we), 32'd0);
        step();
        wr_addr = 16'hA001; wr_data = 8'h32;
        #1;
        chk("ppu prg_we1", 32'(prg_mem_we), 32'd1);
        chk("ppu prg_addr1", 32'(prg_mem_addr), 32'h2000);
        chk("ppu prg_data1", 32'(prg_mem_wdata), 32'h31);
        step();
        prg_wren = 0;
        #1;
        chk("ppu prg_we2", 32'(prg_mem_we), 32'd1);
        chk("ppu prg_addr2", 32'(prg_mem_addr), 32'h2001);
        chk("ppu prg_data2", 32'(prg_mem_wdata), 32'h32);
        chk("ppu vld", 32'(ppu_rd_valid), 32'd1);
        step();
        ppu_rd = 0;
        chk("ppu wcount", 32'(write_count), 32'd14);

        // Test 4: both enables high -> single PRG write
        prg_wren = 1; chr_wren = 1; wr_addr = 16'h0010; wr_data = 8'h5A;
        step();
        prg_wren = 0; chr_wren = 0;
        #1;
        chk("both prg_we", 32'(prg_mem_we), 32'd1);
        chk("both prg_addr", 32'(prg_mem_addr), 32'h10);
        chk("both prg_data", 32'(prg_mem_wdata), 32'h5A);
        chk("both chr_we", 32'(chr_mem_we), 32'd0);
        step();
        chk("both once prg", 32'(prg_mem_we), 32'd0);
        chk("both once chr", 32'(chr_mem_we), 32'd0);
        chk("both wcount", 32'(write_count), 32'd15);

        // CHR write proceeds while a CPU read owns PRG
        chr_wren = 1; wr_addr = 16'h1234; wr_data = 8'h77;
        step();
        chr_wren = 0; cpu_rd = 1; cpu_addr = 15'h0456;
        #1;
        chk("chr we", 32'(chr_mem_we), 32'd1);
        chk("chr addr", 32'(chr_mem_addr), 32'h1234);
        chk("chr data", 32'(chr_mem_wdata), 32'h77);
        chk("chr prg_addr", 32'(prg_mem_addr), 32'h0456);
        chk("chr prg_we", 32'(prg_mem_we), 32'd0);
        step();
        cpu_rd = 0;
        chk("chr wcount", 32'(write_count), 32'd16);

        // Test 5: load_start beats load_done in DRAIN
        load_start = 1;
        step();
        load_start = 0;
        chk("reload state", 32'(state), 32'd0);
        chk("reload wcount", 32'(write_count), 32'd0);
        chk("reload dropped", 32'(wr_dropped), 32'd0);
        chk("reload hold", 32'(nes_reset_hold), 32'd1);
        prg_wren = 1; wr_addr = 16'h0001; wr_data = 8'h99; load_done = 1;
        step();
        prg_wren = 0;
        chk("race drain", 32'(state), 32'd1);
        load_start = 1;
        #1;
        chk("race drain we", 32'(prg_mem_we), 32'd1);
        step();
        load_start = 0; load_done = 0;
        chk("race state", 32'(state), 32'd0);
        chk("race wcount", 32'(write_count), 32'd0);
        chk("race checksum", 32'(checksum), 32'd0);
        chk("race hold", 32'(nes_reset_hold), 32'd1);

        // Test 6: async reset during HOLD
        load_done = 1;
        step();
        load_done = 0;
        chk("t6 drain", 32'(state), 32'd1);
        step();
        chk("t6 hold", 32'(state), 32'd2);
        prg_wren = 1; wr_addr = 16'h0300; wr_data = 8'h22;
        step();
        prg_wren = 0;
        #1;
        chk("t6 hold we", 32'(prg_mem_we), 32'd1);
        chk("t6 hold addr", 32'(prg_mem_addr), 32'h0300);
        step();
        chk("t6 wcount", 32'(write_count), 32'd1);
        cpu_rd = 1; cpu_addr = 15'h0777;
        prg_wren = 1; wr_addr = 16'h0200; wr_data = 8'h11;
        #1;
        chk("t6 rd addr", 32'(prg_mem_addr), 32'h0777);
        chk("t6 rd we", 32'(prg_mem_we), 32'd0);
        step();
        prg_wren = 0;
        chk("t6 cpu_vld", 32'(cpu_rd_valid), 32'd1);
        #2;
        Reset_n = 1'b0;
        #1;
        chk_reset_vals("t6 async");
        cpu_rd = 0;
        #1;
        Reset_n = 1'b1;
        step();
        chk("t6 post state", 32'(state), 32'd0);
        chk("t6 post empty", 32'(prg_mem_we), 32'd0);
        chk("t6 post wr_ready", 32'(wr_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
